// File: rtl/reduce_gate_n.sv
// Pipelined N-input bitwise reduction (AND/OR/XOR and complements) with
// multi-beat packet accumulation between valid/ready producer and consumer.
module reduce_gate_n #(
  parameter int N_IN  = 3,
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [2:0]            in_op,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [1:0] BASE_AND = 2'd0;
  localparam logic [1:0] BASE_OR  = 2'd1;
  localparam logic [1:0] BASE_XOR = 2'd2;

  function automatic logic [1:0] base_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd3: base_of = BASE_AND;
      3'd1, 3'd4: base_of = BASE_OR;
      default:    base_of = BASE_XOR;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] fold(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [2:0]       op);
    case (base_of(op))
      BASE_AND: fold = a & b;
      BASE_OR:  fold = a | b;
      default:  fold = a ^ b;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_red_q, s1_red_d;
  logic [2:0]         s1_op_q, s1_op_d;
  logic               s1_last_q, s1_last_d;
  logic               s1_first_q, s1_first_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_err_q, out_err_d;

  logic [WIDTH-1:0]   word [N_IN];
  logic [2:0]         beat_op;
  logic [WIDTH-1:0]   beat_red;
  logic               in_fire;
  logic               s2_free;
  logic               s1_advance;
  logic               s1_reserved;
  logic [WIDTH-1:0]   combined;
  logic [WIDTH-1:0]   result;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_word
      assign word[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // The op is only sampled on a packet's first beat; later beats reuse the latched op.
  assign beat_op = (state_q == IDLE) ? in_op : op_q;

  always_comb begin
    beat_red = word[0];
    for (int k = 1; k < N_IN; k++) begin
      beat_red = fold(beat_red, word[k], beat_op);
    end
  end

  assign s2_free    = !out_valid_q || out_ready;
  assign s1_advance = s1_valid_q && (!s1_last_q || s2_free);
  assign in_ready   = rst_n && (!s1_valid_q || s1_advance);
  assign in_fire    = in_valid && in_ready;

  // The first-beat flag stands in for the op's identity, so acc content is irrelevant then.
  assign combined    = s1_first_q ? s1_red_q : fold(acc_q, s1_red_q, s1_op_q);
  assign s1_reserved = (s1_op_q[2:1] == 2'b11);
  assign result      = s1_reserved ? '0 : ((s1_op_q >= 3'd3) ? ~combined : combined);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    s1_valid_d  = s1_valid_q;
    s1_red_d    = s1_red_q;
    s1_op_d     = s1_op_q;
    s1_last_d   = s1_last_q;
    s1_first_d  = s1_first_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;

    if (in_fire) begin
      state_d    = in_last ? IDLE : ACCUM;
      if (state_q == IDLE) begin
        op_d = in_op;
      end
      s1_valid_d = 1'b1;
      s1_red_d   = beat_red;
      s1_op_d    = beat_op;
      s1_last_d  = in_last;
      s1_first_d = (state_q == IDLE);
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (s1_advance) begin
      if (s1_last_q) begin
        acc_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = result;
        out_err_d   = s1_reserved;
      end else begin
        acc_d = combined;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_red_q    <= '0;
      s1_op_q     <= '0;
      s1_last_q   <= 1'b0;
      s1_first_q  <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      s1_valid_q  <= s1_valid_d;
      s1_red_q    <= s1_red_d;
      s1_op_q     <= s1_op_d;
      s1_last_q   <= s1_last_d;
      s1_first_q  <= s1_first_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_reduce_gate_n.sv
// Scoreboard bench for reduce_gate_n with N_IN=4, WIDTH=8: a packet model
// pushes expected results on acceptance, a monitor pops them on output.
module tb_reduce_gate_n;

  localparam int N_IN  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [2:0]            in_op;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_err;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             e;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_out  = 0;

  logic             pkt_first = 1'b1;
  logic [2:0]       pkt_op    = 3'd0;
  logic [WIDTH-1:0] pkt_acc   = '0;

  reduce_gate_n #(.N_IN(N_IN), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] comb2(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [2:0] op);
    if (op == 3'd0 || op == 3'd3) return a & b;
    if (op == 3'd1 || op == 3'd4) return a | b;
    return a ^ b;
  endfunction

  function automatic logic [WIDTH-1:0] red_words(input logic [N_IN*WIDTH-1:0] d,
                                                 input logic [2:0] op);
    logic [WIDTH-1:0] r;
    r = d[WIDTH-1:0];
    for (int k = 1; k < N_IN; k++) r = comb2(r, d[k*WIDTH +: WIDTH], op);
    return r;
  endfunction

  // Reference packet model; pushes an expectation on each accepted last beat.
  task automatic model_accept(input logic [N_IN*WIDTH-1:0] d, input logic [2:0] op,
                              input logic last, input logic push);
    exp_t x;
    if (pkt_first) begin
      pkt_op  = op;
      pkt_acc = red_words(d, op);
    end else begin
      pkt_acc = comb2(pkt_acc, red_words(d, pkt_op), pkt_op);
    end
    if (last) begin
      x.e = (pkt_op >= 3'd6);
      x.d = x.e ? '0 : ((pkt_op >= 3'd3) ? ~pkt_acc : pkt_acc);
      if (push) exp_q.push_back(x);
      pkt_first = 1'b1;
    end else begin
      pkt_first = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      n_out++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got data=%h err=%b, required no output", out_data, out_err);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.d || out_err !== e.e) begin
          errors++;
          $display("FAIL sb_result: got data=%h err=%b, required data=%h err=%b",
                   out_data, out_err, e.d, e.e);
        end else begin
          $display("out #%0d data=%h err=%b ok", n_out, out_data, out_err);
        end
      end
    end
  end

  // Offer one beat, hold until accepted (bounded); returns at posedge+1 after acceptance.
  task automatic send_beat(input logic [N_IN*WIDTH-1:0] d, input logic [2:0] op,
                           input logic last, input logic use_model, output int waits);
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_last  = last;
    waits    = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waits);
    end else begin
      model_accept(d, op, last, use_model);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && t < 500) begin
      @(posedge clk);
      #2;
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_op     = 3'd0;
    in_last   = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data: got %h, required 00", out_data); end
    if (out_err !== 1'b0)   begin errors++; $display("FAIL reset_out_err: got %b, required 0", out_err); end
    if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b, required 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_gate3();
    int w;
    logic [2:0] vb;
    logic [N_IN*WIDTH-1:0] d;
    exp_t x;
    // Latency: beat 111 accepted at edge T, result visible after edge T+1.
    x.d = 8'h01; x.e = 1'b0;
    exp_q.push_back(x);
    send_beat({8'hFF, 8'h01, 8'h01, 8'h01}, 3'd0, 1'b1, 1'b0, w);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      errors++;
      $display("FAIL and3_latency: got valid=%b data=%h, required valid=1 data=01", out_valid, out_data);
    end
    wait_drain("and3_latency");
    // AND3 and OR3 truth tables; word 3 carries the op's identity.
    for (int o = 0; o < 2; o++) begin
      for (int v = 0; v < 8; v++) begin
        vb = v[2:0];
        d = {(o == 0) ? 8'hFF : 8'h00, 7'b0, vb[2], 7'b0, vb[1], 7'b0, vb[0]};
        x.d = {7'b0, (o == 0) ? (&vb) : (|vb)};
        x.e = 1'b0;
        exp_q.push_back(x);
        send_beat(d, (o == 0) ? 3'd0 : 3'd1, 1'b1, 1'b0, w);
      end
    end
    in_valid = 1'b0;
    wait_drain("gate3");
  endtask

  task automatic test_multibeat_xnor();
    int w;
    int base;
    exp_t x;
    base = n_out;
    x.d = 8'hE0; x.e = 1'b0;
    exp_q.push_back(x);
    send_beat(32'h08040201, 3'd5, 1'b0, 1'b0, w);
    send_beat(32'h00000010, 3'd0, 1'b1, 1'b0, w);
    in_valid = 1'b0;
    wait_drain("xnor");
    checks++;
    if (n_out - base != 1) begin
      errors++;
      $display("FAIL xnor_count: got %0d outputs, required 1", n_out - base);
    end
  endtask

  task automatic test_backpressure();
    logic [N_IN*WIDTH-1:0] pk [3];
    int idx;
    int base;
    int w;
    pk[0] = 32'h01000000;
    pk[1] = 32'h00200002;
    pk[2] = 32'h40000300;
    base = n_out;
    idx = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'd1;
    in_last   = 1'b1;
    in_data   = pk[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1 && idx < 3) begin
        model_accept(pk[idx], 3'd1, 1'b1, 1'b1);
        idx++;
      end
      @(posedge clk);
      #1;
      if (idx < 3) in_data = pk[idx];
    end
    checks += 3;
    if (idx != 2)          begin errors++; $display("FAIL bp_accepted: got %0d beats, required 2", idx); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
    if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      errors++;
      $display("FAIL bp_hold: got valid=%b data=%h, required valid=1 data=01", out_valid, out_data);
    end
    out_ready = 1'b1;
    send_beat(pk[2], 3'd1, 1'b1, 1'b1, w);
    in_valid = 1'b0;
    wait_drain("bp");
    checks++;
    if (n_out - base != 3) begin
      errors++;
      $display("FAIL bp_count: got %0d outputs, required 3", n_out - base);
    end
  endtask

  task automatic test_reserved();
    int w;
    exp_t x;
    x.d = 8'h00; x.e = 1'b1;
    exp_q.push_back(x);
    send_beat(32'hDEADBEEF, 3'd7, 1'b0, 1'b0, w);
    send_beat(32'h12345678, 3'd1, 1'b1, 1'b0, w);
    x.d = 8'h81; x.e = 1'b0;
    exp_q.push_back(x);
    send_beat(32'h00800001, 3'd1, 1'b1, 1'b0, w);
    in_valid = 1'b0;
    wait_drain("reserved");
  endtask

  task automatic test_reset_mid();
    int w;
    int base;
    exp_t x;
    send_beat(32'h0F0F0F0F, 3'd3, 1'b0, 1'b1, w);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    base = n_out;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b, required 0", out_valid); end
    if (out_data !== '0)    begin errors++; $display("FAIL mid_rst_out_data: got %h, required 00", out_data); end
    if (out_err !== 1'b0)   begin errors++; $display("FAIL mid_rst_out_err: got %b, required 0", out_err); end
    if (in_ready !== 1'b0)  begin errors++; $display("FAIL mid_rst_in_ready: got %b, required 0", in_ready); end
    pkt_first = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    x.d = 8'h30; x.e = 1'b0;
    exp_q.push_back(x);
    send_beat(32'hF53CFFF0, 3'd0, 1'b1, 1'b0, w);
    in_valid = 1'b0;
    wait_drain("reset_mid");
    checks++;
    if (n_out - base != 1) begin
      errors++;
      $display("FAIL mid_rst_count: got %0d outputs, required 1", n_out - base);
    end
  endtask

  task automatic test_streaming();
    int w;
    int stalls;
    int base;
    logic [N_IN*WIDTH-1:0] d;
    logic [2:0] op;
    base = n_out;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      d  = $urandom;
      op = 3'($urandom_range(0, 5));
      send_beat(d, op, 1'b1, 1'b1, w);
      stalls += w;
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks += 2;
    if (stalls != 0) begin
      errors++;
      $display("FAIL stream_stalls: got %0d stall cycles, required 0", stalls);
    end
    if (n_out - base != 100) begin
      errors++;
      $display("FAIL stream_count: got %0d outputs after fill, required 100", n_out - base);
    end
    wait_drain("stream");
  endtask

  initial begin
    test_reset();
    test_gate3();
    test_multibeat_xnor();
    test_backpressure();
    test_reserved();
    test_reset_mid();
    test_streaming();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reduce_gate_n.md
# reduce_gate_n

Parametrised, pipelined N-input bitwise reduction gate: the generalised successor to the fixed 3-input AND3/OR3 cells. Folds N_IN operand words of WIDTH bits with a run-time selected operation (AND, OR, XOR and their complements). It can also accumulate the reduction across a multi-beat packet. It sits between a valid/ready producer and consumer, for example an operand bus feeding a flag or condition register, and replaces chains of discrete 3-input gates.

## Interface
- N_IN, 3: operand words per beat, 2..16.
- WIDTH, 1: bits per operand word and result, 1..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  N_IN*WIDTH  operand k at bits [k*WIDTH +: WIDTH].
- in_op  in  3  0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved.
- in_last  in  1  final beat of a packet; tie high for single-beat use.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  WIDTH  packet result.
- out_err  out  1  result came from a reserved op; qualified by out_valid.

## Operation
- Base function per op: AND for ops 0/3, OR for ops 1/4, XOR for ops 2/5. Ops 3–5 invert the final packet result only, never per beat.
- Stage 1 (S1): registers the per-beat bitwise reduction of the N_IN words, plus op, last and a first-beat flag.
- Stage 2 (S2): holds the accumulator acc, initialised to the identity: all-ones for AND, zero for OR/XOR.
  - Non-last beat leaving S1: acc <= base(acc, s1_red); no output.
  - Last beat leaving S1: out_data <= optional_invert(base(acc, s1_red)); out_valid <= 1; acc returns to identity.
- Packet state machine: IDLE to ACCUM on acceptance of a beat with in_last=0. ACCUM to IDLE on acceptance of a beat with in_last=1.
- Op latch: in_op is sampled only on the first beat of a packet (state IDLE). in_op on later beats is ignored.
- Reserved op (6/7): beats are consumed normally. The result is out_data=0 and out_err=1.
- Output register: out_data and out_err stay stable while out_valid && !out_ready.
- Flow control:
  - s2_free = !out_valid || out_ready.
  - S1 advances when s1_valid && (!s1_last || s2_free).
  - in_ready = !s1_valid || s1_advance.
  - in_ready depends combinationally on out_ready. There is no other combinational in-to-out path.

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_err=0.
  - s1_valid=0, acc=0, state IDLE.
  - in_ready=0 while rst_n is low; in_ready=1 on the first cycle after deassertion.
- Reset asserted mid-packet discards the partial packet and any pending output. No output appears for it.
- Latency: a last beat accepted at edge T gives out_valid=1 after edge T+1, i.e. 2 cycles from presentation.
- Throughput: one beat per cycle with out_ready held high. Back-to-back single-beat packets give out_valid high every cycle.
- Backpressure: out_ready=0 with out_valid=1 stalls only when the beat in S1 is a last beat. Non-last beats keep draining into acc. in_ready drops once S1 holds a blocked last beat.
- Simultaneous events: output consumed and a new last beat moving into S2 on the same edge means out_valid stays 1 with new data. No bubble, no loss.

## Test plan
- Single-beat AND, N_IN=3, WIDTH=1: in_data=3'b111, op 0, last 1 -> out_data=1 two cycles later. Then in_data=3'b101 -> out_data=0. This matches AND3 for all 8 inputs, and OR3 for all 8 with op 1.
- Multi-beat XNOR, N_IN=4, WIDTH=8:
  - beat 1 {0x01,0x02,0x04,0x08}, last 0;
  - beat 2 {0x10,0,0,0}, last 1, in_op=0 on beat 2 (must be ignored);
  - -> single output out_data=0xE0, out_err=0.
- Backpressure: out_ready=0 for 5 cycles while 3 single-beat OR packets are offered -> exactly 2 accepted, in_ready low. Release -> results emerge in order with no loss or duplication.
- Reserved op 7, 2-beat packet -> one output with out_data=0, out_err=1. The next packet with op 1 gives out_err=0.
- Reset mid-packet: assert rst_n low after beat 1 of a 3-beat NAND packet -> all outputs 0 immediately. A fresh single-beat AND packet after release gives the correct result, unaffected by the prior acc.
- Streaming: 100 random single-beat packets with out_ready held high -> 100 outputs matching a reference model, one per cycle after 2-cycle fill.
